vx_mem_responder: RTL



---
 rtl/vx_mem_responder_pkg.sv | 15 +
 rtl/vx_mem_responder_ram.sv | 42 ++++
 rtl/vx_mem_responder_rspq.sv | 52 +++++
 rtl/vx_mem_responder.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/vx_mem_responder_pkg.sv
// Shared constants and elaboration helpers for the local memory responder slice.
`ifndef PERF_CTR_BITS
`define PERF_CTR_BITS 44
`endif

package vx_mem_responder_pkg;

    localparam int PERF_CTR_W = `PERF_CTR_BITS;

    // Index width that stays legal for depth 1.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_mem_responder_ram.sv
// Single-port word RAM with per-byte write enables. The read port is registered
// unless OUT_REG is 0, in which case the selected word is visible combinationally.
module vx_mem_responder_ram
    import vx_mem_responder_pkg::*;
#(
    parameter  int DATAW   = 512,
    parameter  int SIZE    = 4096,
    parameter  int WRENW   = 64,
    parameter  int OUT_REG = 1,
    localparam int ADDRW   = idx_bits(SIZE)
) (
    input  logic             clk,
    input  logic             wren,
    input  logic             rden,
    input  logic [ADDRW-1:0] addr,
    input  logic [WRENW-1:0] byteen,
    input  logic [DATAW-1:0] wdata,
    output logic [DATAW-1:0] rdata
);
    localparam int BYTEW = DATAW / WRENW;

    logic [DATAW-1:0] mem [SIZE];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WRENW; i++) begin
            if (wren && byteen[i])
                mem[addr][i*BYTEW +: BYTEW] <= wdata[i*BYTEW +: BYTEW];
        end
    end

    if (OUT_REG != 0) begin : g_reg
        logic [DATAW-1:0] rdata_q;
        always_ff @(posedge clk) begin
            if (rden)
                rdata_q <= mem[addr];
        end
        assign rdata = rdata_q;
    end else begin : g_comb
        assign rdata = mem[addr];
    end

endmodule

// File: rtl/vx_mem_responder_rspq.sv
// Response FIFO: registered storage, head read straight from the array so the
// head word never changes while it is waiting to be popped.
module vx_mem_responder_rspq
    import vx_mem_responder_pkg::*;
#(
    parameter int DATAW = 520,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [DATAW-1:0] data_in,
    output logic [DATAW-1:0] data_out,
    output logic             empty
);
    localparam int PW = idx_bits(DEPTH);
    localparam int CW = idx_bits(DEPTH + 1);

    logic [DATAW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_ok;

    assign empty  = (cnt_q == '0);
    assign pop_ok = pop && !empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push)
                wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
            if (pop_ok)
                rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
            if (push && !pop_ok)
                cnt_q <= cnt_q + CW'(1);
            else if (!push && pop_ok)
                cnt_q <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_q] <= data_in;
    end

    assign data_out = mem_q[rd_q];

endmodule

// File: rtl/vx_mem_responder.sv
// Memory-bus responder: local RAM answering tagged reads after LATENCY cycles,
// with a credit-guarded response queue and read/write/stall perf counters.
module vx_mem_responder
    import vx_mem_responder_pkg::*;
#(
    parameter int DATA_SIZE  = 64,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8,
    parameter int SIZE       = 4096,
    parameter int LATENCY    = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_rw,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_SIZE-1:0]   req_byteen,
    input  logic [8*DATA_SIZE-1:0] req_data,
    input  logic [TAG_WIDTH-1:0]   req_tag,
    output logic                   req_ready,
    output logic                   rsp_valid,
    output logic [8*DATA_SIZE-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]   rsp_tag,
    input  logic                   rsp_ready,
    output logic [PERF_CTR_W-1:0]  perf_reads,
    output logic [PERF_CTR_W-1:0]  perf_writes,
    output logic [PERF_CTR_W-1:0]  perf_stalls
);
    localparam int DATAW = 8 * DATA_SIZE;
    localparam int IDXW  = idx_bits(SIZE);
    localparam int OUTW  = idx_bits(RSP_DEPTH + 1);

    logic                  req_fire, rd_fire, wr_fire, rsp_fire;
    logic                  ready_q;
    logic [OUTW-1:0]       outstanding_q, outstanding_d;
    logic [DATAW-1:0]      ram_rdata, push_dat;
    logic [TAG_WIDTH-1:0]  push_tag;
    logic                  push_vld, q_empty;
    logic [TAG_WIDTH+DATAW-1:0] q_dout;
    logic [PERF_CTR_W-1:0] reads_q, writes_q, stalls_q;

    assign req_ready = ready_q;
    assign req_fire  = req_valid && ready_q;
    assign rd_fire   = req_fire && !req_rw;
    assign wr_fire   = req_fire && req_rw;
    assign rsp_valid = !q_empty;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Upper address bits alias onto the RAM.
    if (ADDR_WIDTH > IDXW) begin : g_alias
        logic addr_hi_unused;
        assign addr_hi_unused = ^req_addr[ADDR_WIDTH-1:IDXW];
    end

    vx_mem_responder_ram #(
        .DATAW   (DATAW),
        .SIZE    (SIZE),
        .WRENW   (DATA_SIZE),
        .OUT_REG ((LATENCY > 1) ? 1 : 0)
    ) u_ram (
        .clk    (clk),
        .wren   (wr_fire),
        .rden   (rd_fire),
        .addr   (req_addr[IDXW-1:0]),
        .byteen (req_byteen),
        .wdata  (req_data),
        .rdata  (ram_rdata)
    );

    // The RAM output register is stage 1; the queue push is the final stage.
    if (LATENCY == 1) begin : g_lat1
        assign push_vld = rd_fire;
        assign push_tag = req_tag;
        assign push_dat = ram_rdata;
    end else begin : g_latn
        logic [LATENCY-2:0]                vld_pipe;
        logic [LATENCY-2:0][TAG_WIDTH-1:0] tag_pipe;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                vld_pipe <= '0;
            end else begin
                vld_pipe[0] <= rd_fire;
                for (int s = 1; s < LATENCY - 1; s++)
                    vld_pipe[s] <= vld_pipe[s-1];
            end
        end

        always_ff @(posedge clk) begin
            tag_pipe[0] <= req_tag;
            for (int s = 1; s < LATENCY - 1; s++)
                tag_pipe[s] <= tag_pipe[s-1];
        end

        assign push_vld = vld_pipe[LATENCY-2];
        assign push_tag = tag_pipe[LATENCY-2];

        if (LATENCY == 2) begin : g_d0
            assign push_dat = ram_rdata;
        end else begin : g_dn
            logic [LATENCY-3:0][DATAW-1:0] dat_pipe;
            always_ff @(posedge clk) begin
                dat_pipe[0] <= ram_rdata;
                for (int s = 1; s < LATENCY - 2; s++)
                    dat_pipe[s] <= dat_pipe[s-1];
            end
            assign push_dat = dat_pipe[LATENCY-3];
        end
    end

    vx_mem_responder_rspq #(
        .DATAW (TAG_WIDTH + DATAW),
        .DEPTH (RSP_DEPTH)
    ) u_rspq (
        .clk      (clk),
        .reset    (reset),
        .push     (push_vld),
        .pop      (rsp_fire),
        .data_in  ({push_tag, push_dat}),
        .data_out (q_dout),
        .empty    (q_empty)
    );

    assign rsp_tag  = q_dout[TAG_WIDTH+DATAW-1:DATAW];
    assign rsp_data = q_dout[DATAW-1:0];

    // Credits cover both the pipeline and the queue, so a push can never overflow.
    always_comb begin
        outstanding_d = outstanding_q;
        if (rd_fire && !rsp_fire)
            outstanding_d = outstanding_q + OUTW'(1);
        else if (!rd_fire && rsp_fire)
            outstanding_d = outstanding_q - OUTW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding_q <= '0;
            ready_q       <= 1'b0;
            reads_q       <= '0;
            writes_q      <= '0;
            stalls_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            ready_q       <= (outstanding_d < OUTW'(RSP_DEPTH));
            reads_q       <= reads_q + PERF_CTR_W'(rd_fire);
            writes_q      <= writes_q + PERF_CTR_W'(wr_fire);
            stalls_q      <= stalls_q + PERF_CTR_W'(req_valid && !ready_q);
        end
    end

    assign perf_reads  = reads_q;
    assign perf_writes = writes_q;
    assign perf_stalls = stalls_q;

endmodule
